// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the two-core data-memory arbiter: default widths,
// FSM state encoding and the round-robin pick used by the top.
package core_mem_arbiter_pkg;

  localparam int RW_DEF     = 16;
  localparam int ADDR_BYTES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Index of the winning core. When both ask, the core that did not win
  // last time goes first; a lone requester always wins.
  function automatic logic pick_core(input logic req0, input logic req1,
                                     input logic rr_last);
    logic win;
    if (req0 && req1) begin
      win = ~rr_last;
    end else begin
      win = req1;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Bus timeout counter for the memory arbiter. Counts cycles while enabled,
// restarts on clear, and flags expiry on the last allowed cycle so the owner
// can be answered in that same cycle. TIMEOUT_CYCLES of 0 removes the timer.
module mem_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timer
      logic [TO_W-1:0] cnt_q;

      // Count stalled cycles of the current access; a new grant restarts it.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          cnt_q <= '0;
        end else if (clr) begin
          cnt_q <= '0;
        end else if (en) begin
          cnt_q <= cnt_q + TO_W'(1);
        end
      end

      assign expired = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_none
      logic unused_inputs;
      assign unused_inputs = ^{i_clk, i_rst, clr, en};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one downstream data-memory port between
// core0 and core1. One transaction in flight at a time; the winner's payload
// is latched and held until the memory acks or the bus timeout fires.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; any request is granted next edge
// BUSY    | m_mem_req high with latched payload, waiting for ack/timeout
// RELEASE | one cycle after completion; only the non-owner may be granted
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int RW             = RW_DEF,
  parameter int SEL_W          = ADDR_BYTES,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,

  input  logic             c0_mem_req,
  input  logic             c0_mem_we,
  input  logic [RW-1:0]    c0_mem_addr,
  input  logic [RW-1:0]    c0_mem_data,
  input  logic [SEL_W-1:0] c0_mem_sel,
  input  logic             c0_mem_long,
  input  logic [7:0]       c0_mem_addr_high,
  output logic             c0_mem_ack,
  output logic [RW-1:0]    c0_mem_data_i,
  output logic             c0_mem_exception,

  input  logic             c1_mem_req,
  input  logic             c1_mem_we,
  input  logic [RW-1:0]    c1_mem_addr,
  input  logic [RW-1:0]    c1_mem_data,
  input  logic [SEL_W-1:0] c1_mem_sel,
  input  logic             c1_mem_long,
  input  logic [7:0]       c1_mem_addr_high,
  output logic             c1_mem_ack,
  output logic [RW-1:0]    c1_mem_data_i,
  output logic             c1_mem_exception,

  output logic             m_mem_req,
  output logic             m_mem_we,
  output logic [RW-1:0]    m_mem_addr,
  output logic [RW-1:0]    m_mem_data,
  output logic [SEL_W-1:0] m_mem_sel,
  output logic             m_mem_long,
  output logic [7:0]       m_mem_addr_high,
  input  logic [RW-1:0]    m_mem_data_i,
  input  logic             m_mem_ack,
  input  logic             m_mem_err,

  output logic             o_owner
);

  arb_state_t       state_q, state_d;
  logic             owner_q;
  logic             rr_last_q;
  logic             grant;
  logic             grant_id;
  logic             done;
  logic             to_en;
  logic             to_expired;

  logic             nxt_we;
  logic [RW-1:0]    nxt_addr;
  logic [RW-1:0]    nxt_data;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_long;
  logic [7:0]       nxt_addr_high;
  logic [RW-1:0]    rsp_data;
  logic             rsp_exc;

  // Stall timer only runs while waiting on the memory; every grant restarts it.
  assign to_en = (state_q == ST_BUSY) && !m_mem_ack;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clr     (grant),
    .en      (to_en),
    .expired (to_expired)
  );

  // Next-state and grant decision. In RELEASE the owner's request is still
  // the one just served, so only the other core is considered.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c0_mem_req || c1_mem_req) begin
          grant    = 1'b1;
          grant_id = pick_core(c0_mem_req, c1_mem_req, rr_last_q);
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_mem_ack || to_expired) begin
          done    = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        if (owner_q ? c0_mem_req : c1_mem_req) begin
          grant    = 1'b1;
          grant_id = ~owner_q;
          state_d  = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload of the core being granted this cycle.
  always_comb begin
    nxt_we        = c0_mem_we;
    nxt_addr      = c0_mem_addr;
    nxt_data      = c0_mem_data;
    nxt_sel       = c0_mem_sel;
    nxt_long      = c0_mem_long;
    nxt_addr_high = c0_mem_addr_high;
    if (grant_id) begin
      nxt_we        = c1_mem_we;
      nxt_addr      = c1_mem_addr;
      nxt_data      = c1_mem_data;
      nxt_sel       = c1_mem_sel;
      nxt_long      = c1_mem_long;
      nxt_addr_high = c1_mem_addr_high;
    end
  end

  // Route the completion to the owner only. A real ack takes priority over
  // a timeout landing in the same cycle; a timeout returns zero data.
  always_comb begin
    rsp_data         = m_mem_ack ? m_mem_data_i : '0;
    rsp_exc          = m_mem_ack ? m_mem_err : 1'b1;
    c0_mem_ack       = 1'b0;
    c0_mem_data_i    = '0;
    c0_mem_exception = 1'b0;
    c1_mem_ack       = 1'b0;
    c1_mem_data_i    = '0;
    c1_mem_exception = 1'b0;
    if (done && !owner_q) begin
      c0_mem_ack       = 1'b1;
      c0_mem_data_i    = rsp_data;
      c0_mem_exception = rsp_exc;
    end
    if (done && owner_q) begin
      c1_mem_ack       = 1'b1;
      c1_mem_data_i    = rsp_data;
      c1_mem_exception = rsp_exc;
    end
  end

  // State, ownership and the latched downstream request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= 1'b0;
      rr_last_q       <= 1'b1;
      m_mem_req       <= 1'b0;
      m_mem_we        <= 1'b0;
      m_mem_addr      <= '0;
      m_mem_data      <= '0;
      m_mem_sel       <= '0;
      m_mem_long      <= 1'b0;
      m_mem_addr_high <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q         <= grant_id;
        rr_last_q       <= grant_id;
        m_mem_req       <= 1'b1;
        m_mem_we        <= nxt_we;
        m_mem_addr      <= nxt_addr;
        m_mem_data      <= nxt_data;
        m_mem_sel       <= nxt_sel;
        m_mem_long      <= nxt_long;
        m_mem_addr_high <= nxt_addr_high;
      end else if (done) begin
        m_mem_req <= 1'b0;
      end
    end
  end

  assign o_owner = owner_q;

endmodule
